// File: rtl/router_pkg.sv
// Shared types and constants for the router read scheduler: FSM states, header
// field layout and the default starvation timeout.
package router_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_HDR_RD   = 3'd1,
        ST_HDR_WAIT = 3'd2,
        ST_BODY     = 3'd3,
        ST_LAST     = 3'd4,
        ST_ABORT    = 3'd5
    } rd_state_e;

    // Header byte: destination in the low bits, payload length above it.
    localparam int HDR_DEST_W  = 2;
    localparam int HDR_LEN_LSB = 2;
    localparam int HDR_LEN_W   = 6;

    localparam int TIMEOUT_CYCLES_DEFAULT = 30;

    // Reads still owed after the header: the payload bytes plus the parity byte.
    function automatic logic [6:0] hdr_remaining(input logic [7:0] hdr);
        return {1'b0, hdr[HDR_LEN_LSB +: HDR_LEN_W]} + 7'd1;
    endfunction

endpackage

// File: rtl/router_rr_arb.sv
// Three-request round-robin picker; the search starts at the port after the
// previous grant.
module router_rr_arb (
    input  logic [2:0] req,
    input  logic [1:0] last,
    output logic [1:0] gnt_idx,
    output logic       any
);

    // Rotate priority so the port following last is examined first.
    always_comb begin
        any     = |req;
        gnt_idx = 2'd0;
        case (last)
            2'd0: begin
                if (req[1])      gnt_idx = 2'd1;
                else if (req[2]) gnt_idx = 2'd2;
                else             gnt_idx = 2'd0;
            end
            2'd1: begin
                if (req[2])      gnt_idx = 2'd2;
                else if (req[0]) gnt_idx = 2'd0;
                else             gnt_idx = 2'd1;
            end
            default: begin
                if (req[0])      gnt_idx = 2'd0;
                else if (req[1]) gnt_idx = 2'd1;
                else             gnt_idx = 2'd2;
            end
        endcase
    end

endmodule

// File: rtl/router_rd_sched.sv
// Read scheduler merging three router output ports into one packet stream.
// Define ROUTER_RD_SCHED_PARITY_CHK_EN to check the trailing parity byte.
module router_rd_sched
    import router_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEFAULT
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [2:0] valid_in,
    input  logic [7:0] data_in_0,
    input  logic [7:0] data_in_1,
    input  logic [7:0] data_in_2,
    output logic       read_enb_0,
    output logic       read_enb_1,
    output logic       read_enb_2,
    input  logic       sink_ready,
    output logic       m_valid,
    output logic [7:0] m_data,
    output logic       m_sop,
    output logic       m_eop,
    output logic [1:0] m_port,
    output logic       m_err,
    output logic       busy
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    rd_state_e             state_r;
    rd_state_e             state_nxt_s;
    logic [HDR_DEST_W-1:0] port_r;
    logic [HDR_DEST_W-1:0] last_grant_r;
    logic [HDR_DEST_W-1:0] gnt_s;
    logic                  any_s;
    logic [6:0]            rem_r;
    logic [CNT_W-1:0]      starve_cnt_r;
    logic                  rd_prev_r;
    logic                  sel_valid_s;
    logic [7:0]            sel_data_s;
    logic                  rd_issue_s;
    logic                  starve_s;
    logic                  timeout_s;
    logic                  parity_bad_s;

    router_rr_arb u_arb (
        .req     (valid_in),
        .last    (last_grant_r),
        .gnt_idx (gnt_s),
        .any     (any_s)
    );

    // Route the granted port's status and data.
    always_comb begin
        case (port_r)
            2'd0:    begin sel_valid_s = valid_in[0]; sel_data_s = data_in_0; end
            2'd1:    begin sel_valid_s = valid_in[1]; sel_data_s = data_in_1; end
            2'd2:    begin sel_valid_s = valid_in[2]; sel_data_s = data_in_2; end
            default: begin sel_valid_s = 1'b0;        sel_data_s = 8'h00;     end
        endcase
    end

    // A read issues only when the port has data, the sink can take it, and bytes are still owed.
    always_comb begin
        case (state_r)
            ST_HDR_RD: rd_issue_s = sel_valid_s & sink_ready;
            ST_BODY:   rd_issue_s = sel_valid_s & sink_ready & (rem_r != 7'd0);
            default:   rd_issue_s = 1'b0;
        endcase
        starve_s  = (state_r == ST_BODY) & ~sel_valid_s;
        timeout_s = starve_s & (starve_cnt_r == CNT_LAST);
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!resetn) state_r <= ST_IDLE;
        else         state_r <= state_nxt_s;
    end

    // Next-state logic.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE:     state_nxt_s = any_s ? ST_HDR_RD : ST_IDLE;
            ST_HDR_RD:   state_nxt_s = rd_issue_s ? ST_HDR_WAIT : ST_HDR_RD;
            ST_HDR_WAIT: state_nxt_s = ST_BODY;
            ST_BODY: begin
                if (timeout_s)                         state_nxt_s = ST_ABORT;
                else if (rd_issue_s && rem_r == 7'd1)  state_nxt_s = ST_LAST;
                else                                   state_nxt_s = ST_BODY;
            end
            ST_LAST:     state_nxt_s = ST_IDLE;
            ST_ABORT:    state_nxt_s = ST_IDLE;
            default:     state_nxt_s = ST_IDLE;
        endcase
    end

    // Outputs decoded from the state; body data passes straight through from the port.
    always_comb begin
        m_valid = 1'b0;
        m_sop   = 1'b0;
        m_eop   = 1'b0;
        m_err   = 1'b0;
        case (state_r)
            ST_HDR_WAIT: begin m_valid = 1'b1; m_sop = 1'b1; end
            ST_BODY:     m_valid = rd_prev_r;
            ST_LAST:     begin m_valid = 1'b1; m_eop = 1'b1; m_err = parity_bad_s; end
            ST_ABORT:    begin m_eop = 1'b1; m_err = 1'b1; end
            default:     m_valid = 1'b0;
        endcase
        m_data     = m_valid ? sel_data_s : 8'h00;
        read_enb_0 = rd_issue_s & (port_r == 2'd0);
        read_enb_1 = rd_issue_s & (port_r == 2'd1);
        read_enb_2 = rd_issue_s & (port_r == 2'd2);
        busy       = (state_r != ST_IDLE);
        m_port     = port_r;
    end

    // Grant, remaining-byte count, starvation counter and read pipeline flag.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            port_r       <= 2'd0;
            last_grant_r <= 2'd2;
            rem_r        <= 7'd0;
            starve_cnt_r <= '0;
            rd_prev_r    <= 1'b0;
        end else begin
            rd_prev_r <= (state_r == ST_BODY) & rd_issue_s;
            case (state_r)
                ST_IDLE:     if (any_s) port_r <= gnt_s;
                ST_HDR_WAIT: rem_r <= hdr_remaining(sel_data_s);
                ST_BODY:     if (rd_issue_s) rem_r <= rem_r - 7'd1;
                ST_LAST:     last_grant_r <= port_r;
                ST_ABORT:    last_grant_r <= port_r;
                default:     rem_r <= rem_r;
            endcase
            // Back-pressure with data present neither counts nor clears.
            if (state_r != ST_BODY)  starve_cnt_r <= '0;
            else if (!sel_valid_s)   starve_cnt_r <= starve_cnt_r + CNT_ONE;
            else if (sink_ready)     starve_cnt_r <= '0;
            else                     starve_cnt_r <= starve_cnt_r;
        end
    end

`ifdef ROUTER_RD_SCHED_PARITY_CHK_EN
    logic [7:0] acc_r;

    // XOR of header and payload bytes, compared with the parity byte in LAST.
    always_ff @(posedge clk) begin
        if (!resetn)                                acc_r <= 8'h00;
        else if (state_r == ST_HDR_WAIT)            acc_r <= sel_data_s;
        else if (state_r == ST_BODY && rd_prev_r)   acc_r <= acc_r ^ sel_data_s;
        else                                        acc_r <= acc_r;
    end

    assign parity_bad_s = (acc_r != sel_data_s);
`else
    assign parity_bad_s = 1'b0;
`endif

endmodule

// File: tb/tb_router_rd_sched.sv
// Self-checking bench for router_rd_sched: port FIFOs are modelled with queues,
// and the emitted stream is compared against packets predicted at packet level.
module tb_router_rd_sched;

`ifdef ROUTER_RD_SCHED_PARITY_CHK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef struct packed {
        logic       vld;
        logic [7:0] data;
        logic       sop;
        logic       eop;
        logic       err;
        logic [1:0] port;
    } ev_t;

    logic       clk = 1'b0;
    logic       resetn;
    logic [2:0] valid_in;
    logic [7:0] din [3];
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       sink_ready;
    logic       m_valid, m_sop, m_eop, m_err, busy;
    logic [7:0] m_data;
    logic [1:0] m_port;

    logic [7:0] fifo [3][$];
    ev_t        exp_q[$];
    ev_t        obs_q[$];
    logic [2:0] rd_pend, starve_mask;
    int         sink_mode, busy_cnt, mv_cnt, proto_err;
    int         rd_cnt [3];
    logic       last_busy, abort_seen;
    int         vectors, miscompares;

    always #5 clk = ~clk;

    router_rd_sched dut (
        .clk(clk), .resetn(resetn), .valid_in(valid_in),
        .data_in_0(din[0]), .data_in_1(din[1]), .data_in_2(din[2]),
        .read_enb_0(read_enb_0), .read_enb_1(read_enb_1), .read_enb_2(read_enb_2),
        .sink_ready(sink_ready), .m_valid(m_valid), .m_data(m_data),
        .m_sop(m_sop), .m_eop(m_eop), .m_port(m_port), .m_err(m_err), .busy(busy)
    );

    function automatic ev_t mk_ev(input logic v, input logic [7:0] d, input logic s,
                                  input logic e, input logic r, input logic [1:0] p);
        ev_t ev;
        ev.vld = v; ev.data = d; ev.sop = s; ev.eop = e; ev.err = r; ev.port = p;
        return ev;
    endfunction

    function automatic int fifo_total();
        return fifo[0].size() + fifo[1].size() + fifo[2].size();
    endfunction

    task automatic push_ev(input int p, input logic [7:0] d, input logic s, input logic e, input logic r);
        logic [1:0] p2;
        p2 = 2'(p);
        fifo[p].push_back(d);
        exp_q.push_back(mk_ev(1'b1, d, s, e, r, p2));
    endtask

    // Well-formed packet with random payload and correct parity, destination = port.
    task automatic add_packet(input int p, input int len);
        logic [7:0] hdr, b, par;
        logic [5:0] l6;
        logic [1:0] p2;
        l6  = 6'(len);
        p2  = 2'(p);
        hdr = {l6, p2};
        par = hdr;
        push_ev(p, hdr, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < len; i++) begin
            b   = 8'($urandom());
            par = par ^ b;
            push_ev(p, b, 1'b0, 1'b0, 1'b0);
        end
        push_ev(p, par, 1'b0, 1'b1, 1'b0);
    endtask

    // One clock: port FIFO model, input drive, output sampling, then advance to the next negedge.
    task automatic cycle();
        logic [2:0] rds;
        for (int i = 0; i < 3; i++) begin
            if (rd_pend[i]) begin
                if (fifo[i].size() != 0) din[i] = fifo[i].pop_front();
                else                     din[i] = 8'h00;
            end
            valid_in[i] = (fifo[i].size() != 0) && !starve_mask[i];
        end
        case (sink_mode)
            1:       sink_ready = ($urandom_range(0, 3) != 0);
            2:       sink_ready = ~sink_ready;
            default: sink_ready = 1'b1;
        endcase
        #1;
        rds = {read_enb_2, read_enb_1, read_enb_0};
        if ($countones(rds) > 1 || (rds & ~valid_in) != 3'b000 || (rds != 3'b000 && !sink_ready))
            proto_err++;
        if (m_valid | m_sop | m_eop | m_err)
            obs_q.push_back(mk_ev(m_valid, m_valid ? m_data : 8'h00, m_sop, m_eop, m_err, m_port));
        abort_seen = m_eop & ~m_valid;
        last_busy  = busy;
        if (busy)    busy_cnt++;
        if (m_valid) mv_cnt++;
        for (int i = 0; i < 3; i++) if (rds[i]) rd_cnt[i]++;
        rd_pend = rds;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic run_until_done(input int budget);
        int n;
        n = 0;
        while ((obs_q.size() < exp_q.size() || last_busy || fifo_total() != 0) && n < budget) begin
            cycle();
            n++;
        end
        vectors++;
        if (n >= budget) begin
            miscompares++;
            $display("FAIL drain_timeout: obs %0d events, expected %0d within %0d cycles", obs_q.size(), exp_q.size(), budget);
        end
    endtask

    task automatic do_reset();
        resetn = 1'b0;
        for (int i = 0; i < 3; i++) fifo[i].delete();
        exp_q.delete();
        obs_q.delete();
        rd_pend = 3'b000; starve_mask = 3'b000; valid_in = 3'b000; sink_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({read_enb_0, read_enb_1, read_enb_2, m_valid, m_sop, m_eop, m_err, busy} !== 8'h00) begin
            miscompares++;
            $display("FAIL reset_ctrl: got %b expected 00000000", {read_enb_0, read_enb_1, read_enb_2, m_valid, m_sop, m_eop, m_err, busy});
        end
        vectors++;
        if (m_data !== 8'h00) begin miscompares++; $display("FAIL reset_data: got %h expected 00", m_data); end
        vectors++;
        if (m_port !== 2'd0) begin miscompares++; $display("FAIL reset_port: got %0d expected 0", m_port); end
        resetn = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        resetn = 1'b1;
        busy_cnt = 0; mv_cnt = 0; sink_mode = 0;
        add_packet(1, 3);
        run_until_done(100);
        vectors++;
        if (busy_cnt != 7) begin miscompares++; $display("FAIL single_busy: got %0d cycles expected 7", busy_cnt); end
        vectors++;
        if (mv_cnt != 5) begin miscompares++; $display("FAIL single_bytes: got %0d expected 5", mv_cnt); end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL single_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL single_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_all_ports();
        do_reset();
        resetn = 1'b1;
        add_packet(0, 2);
        add_packet(1, 2);
        add_packet(2, 2);
        run_until_done(200);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL order_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL order_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_sink_toggle();
        exp_q.delete(); obs_q.delete();
        rd_cnt = '{0, 0, 0};
        proto_err = 0;
        sink_mode = 2;
        add_packet(0, 6);
        run_until_done(200);
        sink_mode = 0;
        vectors++;
        if (rd_cnt[0] != 8) begin miscompares++; $display("FAIL toggle_reads: got %0d expected 8", rd_cnt[0]); end
        vectors++;
        if (proto_err != 0) begin miscompares++; $display("FAIL toggle_proto: got %0d violations expected 0", proto_err); end
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL toggle_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL toggle_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_abort();
        int n;
        exp_q.delete(); obs_q.delete();
        rd_cnt = '{0, 0, 0};
        sink_mode = 0;
        add_packet(2, 5);
        exp_q = exp_q[0:2];
        exp_q.push_back(mk_ev(1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 2'd2));
        n = 0;
        while (rd_cnt[2] < 3 && n < 50) begin cycle(); n++; end
        starve_mask = 3'b100;
        n = 0;
        abort_seen = 1'b0;
        while (!abort_seen && n < 60) begin cycle(); n++; end
        vectors++;
        if (n != 31) begin miscompares++; $display("FAIL abort_time: got abort at starved cycle %0d expected 31", n); end
        cycle();
        vectors++;
        if (last_busy !== 1'b0) begin miscompares++; $display("FAIL abort_idle: busy %b expected 0", last_busy); end
        fifo[2].delete();
        starve_mask = 3'b000;
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL abort_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL abort_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    task automatic test_parity();
        exp_q.delete(); obs_q.delete();
        push_ev(0, 8'h04, 1'b1, 1'b0, 1'b0);
        push_ev(0, 8'h11, 1'b0, 1'b0, 1'b0);
        push_ev(0, 8'h15, 1'b0, 1'b1, 1'b0);
        push_ev(0, 8'h04, 1'b1, 1'b0, 1'b0);
        push_ev(0, 8'h11, 1'b0, 1'b0, 1'b0);
        push_ev(0, 8'h14, 1'b0, 1'b1, PAR_EN);
        run_until_done(100);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL parity_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL parity_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    // Preloaded random packet mixes; expected order follows round-robin over non-empty ports.
    task automatic test_random();
        int cnt [3];
        int last, p, len, total;
        proto_err = 0;
        for (int it = 0; it < 4; it++) begin
            do_reset();
            resetn = 1'b1;
            sink_mode = 1;
            total = 0;
            for (int i = 0; i < 3; i++) begin cnt[i] = $urandom_range(0, 3); total += cnt[i]; end
            last = 2;
            while (total > 0) begin
                p = (last + 1) % 3;
                while (cnt[p] == 0) p = (p + 1) % 3;
                len = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(1, 12);
                add_packet(p, len);
                cnt[p]--; total--; last = p;
            end
            run_until_done(3000);
            vectors++;
            if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL rand_len[%0d]: got %0d expected %0d", it, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
                vectors++;
                if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL rand_ev[%0d][%0d]: got %h expected %h", it, i, obs_q[i], exp_q[i]); end
            end
        end
        sink_mode = 0;
        vectors++;
        if (proto_err != 0) begin miscompares++; $display("FAIL rand_proto: got %0d violations expected 0", proto_err); end
    endtask

    task automatic test_reset_mid();
        int n;
        do_reset();
        resetn = 1'b1;
        rd_cnt = '{0, 0, 0};
        add_packet(1, 8);
        n = 0;
        while (rd_cnt[1] < 4 && n < 50) begin cycle(); n++; end
        do_reset();
        vectors++;
        if ({read_enb_0, read_enb_1, read_enb_2, m_valid, m_sop, m_eop, m_err, busy} !== 8'h00) begin
            miscompares++;
            $display("FAIL midreset_ctrl: got %b expected 00000000", {read_enb_0, read_enb_1, read_enb_2, m_valid, m_sop, m_eop, m_err, busy});
        end
        vectors++;
        if ({m_data, m_port} !== 10'h000) begin miscompares++; $display("FAIL midreset_data: got %h/%0d expected 00/0", m_data, m_port); end
        resetn = 1'b1;
        add_packet(0, 2);
        add_packet(2, 1);
        run_until_done(200);
        vectors++;
        if (obs_q.size() != exp_q.size()) begin miscompares++; $display("FAIL midreset_len: got %0d expected %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
            vectors++;
            if (obs_q[i] !== exp_q[i]) begin miscompares++; $display("FAIL midreset_ev[%0d]: got %h expected %h", i, obs_q[i], exp_q[i]); end
        end
    endtask

    initial begin
        vectors = 0; miscompares = 0;
        resetn = 1'b0; valid_in = 3'b000; sink_ready = 1'b0;
        din[0] = 8'h00; din[1] = 8'h00; din[2] = 8'h00;
        rd_pend = 3'b000; starve_mask = 3'b000;
        sink_mode = 0; busy_cnt = 0; mv_cnt = 0; proto_err = 0;
        rd_cnt = '{0, 0, 0};
        last_busy = 1'b0; abort_seen = 1'b0;
        test_reset();
        test_single();
        test_all_ports();
        test_sink_toggle();
        test_abort();
        test_parity();
        test_random();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
